// File: rtl/blake2_bus_seq.sv
// Host-side sequencer for the BLAKE2 core's 8-bit bus: config frame, zero-padded blocks, digest readback.
// Optional stall watchdog is compiled in with BLAKE2_BUS_SEQ_TIMEOUT_EN.
module blake2_bus_seq #(
  parameter int BLOCK_BYTES = 64,
  parameter int LL_W        = 32
`ifdef BLAKE2_BUS_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [7:0]      kk_i,
  input  logic [7:0]      nn_i,
  input  logic [LL_W-1:0] ll_i,
  input  logic [7:0]      msg_data_i,
  input  logic            msg_valid_i,
  output logic            msg_ready_o,
  output logic [7:0]      bus_data_o,
  output logic [2:0]      bus_ctrl_o,
  input  logic [1:0]      core_ctrl_i,
  input  logic [7:0]      core_hash_i,
  output logic [7:0]      hash_data_o,
  output logic            hash_valid_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam int CW    = LL_W + 1;
  localparam logic [1:0] CMD_CONF = 2'b00;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_LAST = 2'b10;

  typedef enum logic [2:0] {
    IDLE, CONF, WAIT_RDY, BLOCK, WAIT_HASH, FIN
  } state_t;

  state_t           state;
  logic [7:0]       kk;
  logic [7:0]       nn;
  logic [LL_W-1:0]  ll;
  logic [CW-1:0]    host_left;
  logic [CW-1:0]    blk_left;
  logic [IDX_W-1:0] idx;
  logic [2:0]       conf_idx;
  logic [7:0]       hash_cnt;

  logic [CW-1:0]    total;
  logic [CW-1:0]    nblk_raw;
  logic             bad_job;
  logic [31:0]      ll32;
  logic [7:0]       conf_byte;
  logic             last_blk;
  logic [1:0]       blk_cmd;
  logic             step;
  logic             block_ready;
  logic             hash_vld;

  assign block_ready = core_ctrl_i[0];
  assign hash_vld    = core_ctrl_i[1];

  // A non-zero key occupies one whole block ahead of the message.
  assign total    = {1'b0, ll_i} + ((kk_i != 8'd0) ? CW'(BLOCK_BYTES) : '0);
  assign nblk_raw = (total + CW'(BLOCK_BYTES - 1)) >> IDX_W;
  assign bad_job  = (kk_i > 8'd64) || (nn_i == 8'd0) || (nn_i > 8'd64);

  assign ll32     = 32'(ll);
  assign last_blk = (blk_left == CW'(1));
  assign blk_cmd  = last_blk ? CMD_LAST : CMD_DATA;

  assign msg_ready_o = (state == BLOCK) && (host_left != '0);
  assign step        = (state == BLOCK) && ((host_left == '0) || msg_valid_i);

  always_comb begin
    case (conf_idx)
      3'd0:    conf_byte = kk;
      3'd1:    conf_byte = nn;
      3'd2:    conf_byte = ll32[7:0];
      3'd3:    conf_byte = ll32[15:8];
      3'd4:    conf_byte = ll32[23:16];
      default: conf_byte = ll32[31:24];
    endcase
  end

`ifdef BLAKE2_BUS_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;
  logic            waiting;
  logic            progress;

  assign waiting  = (state == WAIT_RDY) || (state == WAIT_HASH);
  assign progress = ((state == WAIT_RDY) && block_ready) ||
                    ((state == WAIT_HASH) && hash_vld);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      kk           <= 8'h00;
      nn           <= 8'h00;
      ll           <= '0;
      host_left    <= '0;
      blk_left     <= '0;
      idx          <= '0;
      conf_idx     <= 3'd0;
      hash_cnt     <= 8'h00;
      bus_data_o   <= 8'h00;
      bus_ctrl_o   <= 3'b000;
      hash_data_o  <= 8'h00;
      hash_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
`ifdef BLAKE2_BUS_SEQ_TIMEOUT_EN
      wd           <= '0;
`endif
    end else begin
      bus_data_o   <= 8'h00;
      bus_ctrl_o   <= 3'b000;
      hash_data_o  <= 8'h00;
      hash_valid_o <= 1'b0;
      done_o       <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            kk        <= kk_i;
            nn        <= nn_i;
            ll        <= ll_i;
            host_left <= total;
            blk_left  <= (nblk_raw == '0) ? CW'(1) : nblk_raw;
            conf_idx  <= 3'd0;
            idx       <= '0;
            hash_cnt  <= 8'h00;
            if (bad_job) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
            end else begin
              err_o  <= 1'b0;
              busy_o <= 1'b1;
              state  <= CONF;
            end
          end
        end

        CONF: begin
          bus_ctrl_o <= {CMD_CONF, 1'b1};
          bus_data_o <= conf_byte;
          conf_idx   <= conf_idx + 3'd1;
          if (conf_idx == 3'd5) state <= WAIT_RDY;
        end

        WAIT_RDY: begin
          if (block_ready) state <= BLOCK;
        end

        // Host bytes first, then zero fill; block_ready is not re-checked mid-block.
        BLOCK: begin
          if (step) begin
            bus_ctrl_o <= {blk_cmd, 1'b1};
            if (host_left != '0) begin
              bus_data_o <= msg_data_i;
              host_left  <= host_left - CW'(1);
            end
            if (idx == IDX_W'(BLOCK_BYTES - 1)) begin
              idx      <= '0;
              blk_left <= blk_left - CW'(1);
              state    <= last_blk ? WAIT_HASH : WAIT_RDY;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        WAIT_HASH: begin
          if (hash_vld) begin
            hash_data_o  <= core_hash_i;
            hash_valid_o <= 1'b1;
            hash_cnt     <= hash_cnt + 8'd1;
            if (hash_cnt == nn - 8'd1) state <= FIN;
          end
        end

        FIN: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if (hash_vld && (state != WAIT_HASH)) err_o <= 1'b1;

`ifdef BLAKE2_BUS_SEQ_TIMEOUT_EN
      if (!waiting || progress) begin
        wd <= '0;
      end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
        wd     <= '0;
        err_o  <= 1'b1;
        done_o <= 1'b1;
        busy_o <= 1'b0;
        state  <= IDLE;
      end else begin
        wd <= wd + WD_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_blake2_bus_seq.sv
// Bench for blake2_bus_seq: expected bus stream built per job from the framing rules, with a simple core model.
module tb_blake2_bus_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  kk_i, nn_i;
  logic [31:0] ll_i;
  logic [7:0]  msg_data_i;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [7:0]  bus_data_o;
  logic [2:0]  bus_ctrl_o;
  logic [1:0]  core_ctrl_i;
  logic [7:0]  core_hash_i;
  logic [7:0]  hash_data_o;
  logic        hash_valid_o;
  logic        busy_o, done_o, err_o;

  blake2_bus_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .bus_data_o(bus_data_o), .bus_ctrl_o(bus_ctrl_o), .core_ctrl_i(core_ctrl_i),
    .core_hash_i(core_hash_i), .hash_data_o(hash_data_o), .hash_valid_o(hash_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] msg     [0:511];
  logic [9:0] exp_bus [0:1023];
  int msg_len = 0, exp_len = 0, exp_nn = 0, cur_nn = 0, job_id = 0;
  int bus_rd = 0, hash_rd = 0, done_cnt = 0, hs_cnt = 0;
  bit rdy_en = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] hbyte(input int j, input int i);
    return 8'(32'hC3 ^ (i * 5) ^ j);
  endfunction

  task automatic push(input logic [1:0] c, input logic [7:0] d);
    exp_bus[exp_len] = {c, d};
    exp_len++;
  endtask

  // Reference stream: 6 CONF bytes, then nblk blocks of host bytes followed by zero fill.
  task automatic build_exp(input int kk, input int nn, input int ll, input bit abc);
    int total, nblk, p;
    logic [31:0] llv;
    total = ll + ((kk != 0) ? 64 : 0);
    nblk  = (total == 0) ? 1 : (total + 63) / 64;
    for (int i = 0; i < total && i < 512; i++) msg[i] = 8'(i * 13 + 7);
    if (abc) begin msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; end
    msg_len = total;
    llv = 32'(ll);
    exp_len = 0;
    push(2'b00, 8'(kk)); push(2'b00, 8'(nn));
    push(2'b00, llv[7:0]); push(2'b00, llv[15:8]); push(2'b00, llv[23:16]); push(2'b00, llv[31:24]);
    for (int b = 0; b < nblk; b++)
      for (int i = 0; i < 64; i++) begin
        p = b * 64 + i;
        push((b == nblk - 1) ? 2'b10 : 2'b01, (p < total) ? msg[p] : 8'h00);
      end
    exp_nn = nn;
    cur_nn = nn;
  endtask

  task automatic start_job(input int kk, input int nn, input int ll);
    job_id++;
    @(negedge clk); @(negedge clk);
    start_i = 1'b1; kk_i = 8'(kk); nn_i = 8'(nn); ll_i = 32'(ll);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_job(input int kk, input int nn, input int ll, input bit stall, input bit restart);
    int c;
    start_job(kk, nn, ll);
    check("busy_after_start", {busy_o, err_o}, 2'b10);
    if (restart) begin
      repeat (20) @(negedge clk);
      start_i = 1'b1; kk_i = 8'd0; nn_i = 8'd1; ll_i = 32'd1;
      @(negedge clk);
      start_i = 1'b0;
    end
    if (stall) begin
      for (c = 0; c < 2000 && bus_rd < 38; c++) @(negedge clk);
      check("stall_reach_mid_block", 32'(bus_rd >= 38), 1);
      rdy_en = 1'b0;
      repeat (50) @(negedge clk);
      check("stall_bus_silent", bus_rd, 70);
      rdy_en = 1'b1;
    end
    for (c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("bus_bytes_all", bus_rd, exp_len);
    check("hash_bytes_all", hash_rd, nn);
    check("msg_handshakes", hs_cnt, msg_len);
    check("err_clear", {busy_o, err_o}, 2'b00);
  endtask

  // Host byte source with a bubble every fifth cycle.
  initial begin : host_drv
    bit hs;
    int ptr, tick, drv_job;
    ptr = 0; tick = 0; drv_job = 0;
    msg_valid_i = 1'b0; msg_data_i = 8'h00;
    forever begin
      @(negedge clk);
      hs = msg_valid_i && msg_ready_o;
      @(posedge clk);
      if (job_id != drv_job) begin drv_job = job_id; ptr = 0; hs_cnt = 0; end
      else if (hs) begin ptr++; hs_cnt++; end
      #1;
      tick++;
      if (ptr < msg_len && (tick % 5) != 0) begin msg_valid_i = 1'b1; msg_data_i = msg[ptr]; end
      else begin msg_valid_i = 1'b0; msg_data_i = 8'h00; end
    end
  end

  // Core model: digest follows three cycles after the 64th DATA_LAST byte.
  initial begin : core_model
    int last_cnt, hash_pend, hash_i, hdelay;
    last_cnt = 0; hash_pend = 0; hash_i = 0; hdelay = 0;
    core_ctrl_i = 2'b00; core_hash_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      core_ctrl_i = {1'b0, rdy_en};
      core_hash_i = 8'h00;
      if (!rst_n) begin
        last_cnt = 0; hash_pend = 0; hdelay = 0;
      end else begin
        if (bus_ctrl_o == 3'b101) last_cnt++;
        if (last_cnt == 64) begin
          last_cnt = 0; hash_pend = cur_nn; hash_i = 0; hdelay = 3;
        end else if (hdelay > 0) begin
          hdelay--;
        end else if (hash_pend > 0) begin
          core_ctrl_i[1] = 1'b1;
          core_hash_i = hbyte(job_id, hash_i);
          hash_i++; hash_pend--;
        end
      end
    end
  end

  initial begin : compare
    int seen;
    bit exp_done_next;
    seen = 0; exp_done_next = 1'b0;
    forever begin
      @(negedge clk);
      if (job_id != seen) begin
        seen = job_id; bus_rd = 0; hash_rd = 0; done_cnt = 0; exp_done_next = 1'b0;
      end
      if (exp_done_next) begin
        check("done_after_last_hash", {done_o, busy_o}, 2'b10);
        exp_done_next = 1'b0;
      end
      if (done_o) done_cnt++;
      if (bus_ctrl_o[0]) begin
        if (bus_rd < exp_len) check("bus_byte", {bus_ctrl_o[2:1], bus_data_o}, exp_bus[bus_rd]);
        else check("bus_extra_valid", {bus_ctrl_o, bus_data_o}, 0);
        bus_rd++;
      end
      if (hash_valid_o) begin
        if (hash_rd < exp_nn) check("hash_byte", hash_data_o, hbyte(job_id, hash_rd));
        else check("hash_extra_valid", 1, 0);
        hash_rd++;
        if (hash_rd == exp_nn) exp_done_next = 1'b1;
      end
    end
  end

  function automatic logic [23:0] outs();
    return {bus_data_o, bus_ctrl_o, hash_data_o, hash_valid_o, msg_ready_o, busy_o, done_o, err_o};
  endfunction

  initial begin : main
    int c;
    start_i = 1'b0; kk_i = 8'h00; nn_i = 8'h00; ll_i = 32'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "abc", single DATA_LAST block.
    build_exp(0, 32, 3, 1'b1);
    check("model_len_abc", exp_len, 70);
    check("model_conf_kk", exp_bus[0], 10'h000);
    check("model_conf_nn", exp_bus[1], 10'h020);
    check("model_conf_ll0", exp_bus[2], 10'h003);
    check("model_first_data", exp_bus[6], 10'h261);
    check("model_third_data", exp_bus[8], 10'h263);
    check("model_first_pad", exp_bus[9], 10'h200);
    run_job(0, 32, 3, 1'b0, 1'b0);

    // Two full blocks, no padding; a second start mid-job must be ignored.
    build_exp(0, 64, 128, 1'b0);
    check("model_len_128", exp_len, 134);
    check("model_conf_ll_128", exp_bus[2], 10'h080);
    check("model_blk1_last", exp_bus[69], 10'h13A);
    check("model_blk2_first", exp_bus[70], 10'h247);
    run_job(0, 64, 128, 1'b0, 1'b1);

    // Key block only.
    build_exp(16, 64, 0, 1'b0);
    check("model_len_key", exp_len, 70);
    check("model_key_first", exp_bus[6], 10'h207);
    run_job(16, 64, 0, 1'b0, 1'b0);

    // ll=65 with block_ready withheld before block 2.
    build_exp(0, 16, 65, 1'b0);
    check("model_len_65", exp_len, 134);
    check("model_65_blk2_data", exp_bus[70], 10'h247);
    check("model_65_blk2_pad", exp_bus[71], 10'h200);
    run_job(0, 16, 65, 1'b1, 1'b0);

    // nn=0 rejected.
    exp_len = 0; exp_nn = 0; msg_len = 0;
    start_job(0, 0, 10);
    check("bad_job_done_next", {done_o, err_o, busy_o}, 3'b110);
    @(negedge clk);
    check("bad_job_done_once", done_o, 0);
    repeat (20) @(negedge clk);
    check("bad_job_no_bus", bus_rd, 0);
    check("bad_job_err_sticky", err_o, 1);
    check("bad_job_done_cnt", done_cnt, 1);

    // Reset mid-block, then a fresh job.
    build_exp(0, 8, 100, 1'b0);
    start_job(0, 8, 100);
    check("start_clears_err", {busy_o, err_o}, 2'b10);
    for (c = 0; c < 500 && bus_rd < 20; c++) @(negedge clk);
    check("reach_mid_block", 32'(bus_rd >= 20), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    check("held_reset_outputs", outs(), 0);
    rst_n = 1'b1;
    build_exp(5, 8, 5, 1'b0);
    check("model_len_k5", exp_len, 134);
    check("model_conf_k5", exp_bus[0], 10'h005);
    run_job(5, 8, 5, 1'b0, 1'b0);

`ifdef BLAKE2_BUS_SEQ_TIMEOUT_EN
    build_exp(0, 8, 1, 1'b0);
    exp_len = 6;
    rdy_en = 1'b0;
    start_job(0, 8, 1);
    for (c = 0; c < 5000 && done_cnt == 0; c++) @(negedge clk);
    check("timeout_not_early", 32'(c >= 4080), 1);
    check("timeout_done", done_cnt, 1);
    check("timeout_err", {err_o, busy_o}, 2'b10);
    check("timeout_conf_only", bus_rd, 6);
    rdy_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/blake2_bus_seq.md
Name: blake2_bus_seq

Overview:
- Host-side sequencer for the BLAKE2 hash core's 8-bit parallel bus.
- Takes a job descriptor (kk, nn, ll) and a message byte stream from the host.
- Issues the config frame, then streams 64-byte blocks, zero-padding the final block.
- Collects nn digest bytes back from the core. Sits between the host interface logic and the core's ui_in / uio_in / uo_out pins.

Parameters:
- BLOCK_BYTES, 64, bytes per block.
- LL_W, 32, width of the message-length field.
- TIMEOUT_CYC, 4096, watchdog limit in cycles (only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; starts a job. Ignored unless busy_o=0.
- kk_i  in  8  key length in bytes (0..64), sampled at start_i.
- nn_i  in  8  digest length in bytes (1..64), sampled at start_i.
- ll_i  in  LL_W  message length in bytes, sampled at start_i.
- msg_data_i  in  8  message byte (key block first if kk>0).
- msg_valid_i  in  1  msg_data_i valid.
- msg_ready_o  out  1  byte accepted when valid&ready.
- bus_data_o  out  8  byte to core ui_in.
- bus_ctrl_o  out  3  {cmd[1:0], valid} to core uio_in[2:0].
- core_ctrl_i  in  2  {hash_valid, block_ready} from core.
- core_hash_i  in  8  digest byte from core uo_out.
- hash_data_o  out  8  digest byte to host.
- hash_valid_o  out  1  hash_data_o valid.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse after the last digest byte.
- err_o  out  1  sticky error; cleared by start_i.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Commands: 00 = CONF, 01 = DATA, 10 = DATA_LAST, 11 = reserved (never driven).
- Block count:
  - total = ll + (kk!=0 ? BLOCK_BYTES : 0).
  - nblk = max(1, ceil(total/BLOCK_BYTES)).
  - Computed at start_i in LL_W+1 bits.
  - Host-supplied byte count = total.
- FSM:
  - IDLE: on start_i, latch fields, clear err_o, set busy_o -> CONF.
  - CONF: drive 6 bytes with cmd=00, valid=1, one per cycle: kk, nn, ll[7:0], ll[15:8], ll[23:16], ll[31:24]. ll bits beyond LL_W are driven as 0. -> WAIT_RDY.
  - WAIT_RDY: wait for block_ready=1 -> BLOCK.
  - BLOCK:
    - Byte index 0..BLOCK_BYTES-1. cmd=10 on the last block, else 01.
    - While host bytes remain: msg_ready_o=1; bus valid is asserted exactly in the accepted cycle, data=msg_data_i registered (1-cycle latency from acceptance to bus).
    - Once host bytes are exhausted: msg_ready_o=0 and the remaining bytes are 0x00, one per cycle, no stalls.
    - After the index wraps: -> WAIT_RDY, or WAIT_HASH if this was the last block.
  - WAIT_HASH: each cycle with hash_valid=1, forward core_hash_i to hash_data_o/hash_valid_o with 1-cycle registered latency and count. After nn bytes -> IDLE, done_o pulses the cycle after the last hash_valid_o, busy_o drops the same cycle.
- Boundaries:
  - ll=0, kk=0: one DATA_LAST block of 64 zero bytes.
  - ll a multiple of 64 (ll>0): no extra padding block.
  - hash_valid outside WAIT_HASH: ignored; sets err_o.
  - block_ready deasserting mid-block: ignored (core buffers a full block).
  - Bus valid never asserts in IDLE, WAIT_RDY or WAIT_HASH.
  - kk>64 or nn=0 or nn>64 at start: err_o=1, no bus activity, done_o pulses the next cycle.
  - start_i while busy: ignored.
  - rst_n low mid-job: immediate return to reset values, outputs 0.

Optional Feature:
- BLAKE2_BUS_SEQ_TIMEOUT_EN defined: a watchdog counts cycles spent in WAIT_RDY or WAIT_HASH without progress (no block_ready / hash_valid). At TIMEOUT_CYC it sets err_o, pulses done_o and returns to IDLE.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- kk=0, nn=32, ll=3, bytes "abc" -> CONF bytes 00,20,03,00,00,00; one block cmd=10: 61,62,63 then 61 zeros; 32 hash bytes forwarded; done_o pulses once.
- kk=0, nn=64, ll=128 -> two blocks, cmd 01 then 10, no padding bytes; 128 msg handshakes.
- kk=16, nn=64, ll=0 -> total=64, single DATA_LAST block consisting of the host key block; 64 hash bytes.
- ll=65 with block_ready held low 50 cycles before block 2 -> bus valid silent while waiting; block 2 = 1 data byte + 63 zeros.
- Assert rst_n low mid-BLOCK, then start a new job -> outputs 0 during reset; the new job's CONF frame is correct.
- nn=0 -> err_o=1, no bus valid, done_o next cycle. With the macro: block_ready never asserted -> err_o after 4096 cycles.
